// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), derived totals and sync windows,
// plus the registered output bundle used by the generator.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE_DFLT = 640;
  localparam int unsigned H_FRONT_DFLT   = 16;
  localparam int unsigned H_SYNC_DFLT    = 96;
  localparam int unsigned H_BACK_DFLT    = 48;
  localparam int unsigned V_VISIBLE_DFLT = 480;
  localparam int unsigned V_FRONT_DFLT   = 10;
  localparam int unsigned V_SYNC_DFLT    = 2;
  localparam int unsigned V_BACK_DFLT    = 33;
  localparam int unsigned CLK_DIV_DFLT   = 4;

  function automatic int unsigned line_total(input int unsigned visible,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return visible + front + sync + back;
  endfunction

  function automatic int unsigned sync_start(input int unsigned visible,
                                             input int unsigned front);
    return visible + front;
  endfunction

  function automatic int unsigned sync_end(input int unsigned visible,
                                           input int unsigned front,
                                           input int unsigned sync);
    return visible + front + sync - 1;
  endfunction

  localparam int unsigned H_TOTAL = line_total(H_VISIBLE_DFLT, H_FRONT_DFLT, H_SYNC_DFLT,
                                               H_BACK_DFLT);
  localparam int unsigned V_TOTAL = line_total(V_VISIBLE_DFLT, V_FRONT_DFLT, V_SYNC_DFLT,
                                               V_BACK_DFLT);

  localparam int unsigned H_SYNC_START = sync_start(H_VISIBLE_DFLT, H_FRONT_DFLT);
  localparam int unsigned H_SYNC_END   = sync_end(H_VISIBLE_DFLT, H_FRONT_DFLT, H_SYNC_DFLT);
  localparam int unsigned V_SYNC_START = sync_start(V_VISIBLE_DFLT, V_FRONT_DFLT);
  localparam int unsigned V_SYNC_END   = sync_end(V_VISIBLE_DFLT, V_FRONT_DFLT, V_SYNC_DFLT);

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic [9:0] h_cnt;
    logic [8:0] v_cnt;
    logic       frame_start;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_RESET = '{
    hsync:       1'b1,
    vsync:       1'b1,
    valid:       1'b0,
    h_cnt:       10'd0,
    v_cnt:       9'd0,
    frame_start: 1'b0
  };

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing outputs of the VGA generator, driven by the master and observed by the slave.
interface vga_timing_gen_if;

  logic       pixel_tick;
  logic       hsync;
  logic       vsync;
  logic       valid;
  logic [9:0] h_cnt;
  logic [8:0] v_cnt;
  logic       frame_start;

  modport master (
    output pixel_tick,
    output hsync,
    output vsync,
    output valid,
    output h_cnt,
    output v_cnt,
    output frame_start
  );

  modport slave (
    input pixel_tick,
    input hsync,
    input vsync,
    input valid,
    input h_cnt,
    input v_cnt,
    input frame_start
  );

endinterface

// File: rtl/pixel_tick_div.sv
// Pixel-rate prescaler: counts 0..CLK_DIV-1 and pulses tick in the last count.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = $clog2(CLK_DIV);
  localparam logic [W-1:0] CntLast = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: h/v raster counters advanced by the pixel prescaler, with all
// sync/valid/count outputs registered from the next-state counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DFLT,
  parameter int unsigned H_FRONT   = H_FRONT_DFLT,
  parameter int unsigned H_SYNC    = H_SYNC_DFLT,
  parameter int unsigned H_BACK    = H_BACK_DFLT,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DFLT,
  parameter int unsigned V_FRONT   = V_FRONT_DFLT,
  parameter int unsigned V_SYNC    = V_SYNC_DFLT,
  parameter int unsigned V_BACK    = V_BACK_DFLT,
  parameter int unsigned CLK_DIV   = CLK_DIV_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int unsigned HTotal = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncFirst = 10'(sync_start(H_VISIBLE, H_FRONT));
  localparam logic [9:0] HSyncLast  = 10'(sync_end(H_VISIBLE, H_FRONT, H_SYNC));
  localparam logic [9:0] VSyncFirst = 10'(sync_start(V_VISIBLE, V_FRONT));
  localparam logic [9:0] VSyncLast  = 10'(sync_end(V_VISIBLE, V_FRONT, V_SYNC));

  logic       tick;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  vga_out_t   out_q, out_d;

  pixel_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick_div (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Raster counters; a line wrap on the last line lands on (0,0) in one edge.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Outputs derive from the next-state counters so they update on the counter edge.
  always_comb begin
    out_d             = VGA_OUT_RESET;
    out_d.valid       = (h_d < HVis) && (v_d < VVis);
    out_d.hsync       = !((h_d >= HSyncFirst) && (h_d <= HSyncLast));
    out_d.vsync       = !((v_d >= VSyncFirst) && (v_d <= VSyncLast));
    out_d.h_cnt       = out_d.valid ? h_d : 10'd0;
    out_d.v_cnt       = out_d.valid ? v_d[8:0] : 9'd0;
    out_d.frame_start = tick && (h_d == 10'd0) && (v_d == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= HLast;
      v_q   <= VLast;
      out_q <= VGA_OUT_RESET;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      out_q <= out_d;
    end
  end

  assign vga.pixel_tick  = tick;
  assign vga.hsync       = out_q.hsync;
  assign vga.vsync       = out_q.vsync;
  assign vga.valid       = out_q.valid;
  assign vga.h_cnt       = out_q.h_cnt;
  assign vga.v_cnt       = out_q.v_cnt;
  assign vga.frame_start = out_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster: per-clk scoreboard from a closed-form
// timing model, plus interval measurements on sync, frame and active-pixel behaviour.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 4, HS = 8, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int DIV = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME_CLKS = HT * VT * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_timing_gen_if vga ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV  (DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vga)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $display("FAIL %s timed out", tag);
  endtask

  // Scoreboard: model predicts the cycle following each posedge from clocks since reset.
  logic [23:0] exp_q[$];
  int k  = 1;
  int p  = -1;
  int mh = HT - 1;
  int mv = VT - 1;

  always @(posedge clk) begin
    logic       e_tick, e_hs, e_vs, e_valid, e_fs;
    logic [9:0] e_hc;
    logic [8:0] e_vc;
    if (rst) k = 1;
    else k = k + 1;
    p = (k - 1) / DIV - 1;
    if (p < 0) begin
      mh = HT - 1;
      mv = VT - 1;
    end else begin
      mh = p % HT;
      mv = (p / HT) % VT;
    end
    e_tick  = ((k - 1) % DIV) == DIV - 1;
    e_valid = (mh < HV) && (mv < VV);
    e_hs    = !((mh >= HV + HF) && (mh < HV + HF + HS));
    e_vs    = !((mv >= VV + VF) && (mv < VV + VF + VS));
    e_hc    = e_valid ? 10'(mh) : 10'd0;
    e_vc    = e_valid ? 9'(mv) : 9'd0;
    e_fs    = (((k - 1) % DIV) == 0) && (p >= 0) && (mh == 0) && (mv == 0);
    if (rst) exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0});
    else exp_q.push_back({e_tick, e_hs, e_vs, e_valid, e_hc, e_vc, e_fs});
  end

  always @(negedge clk) begin
    logic [23:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("outputs", {vga.pixel_tick, vga.hsync, vga.vsync, vga.valid, vga.h_cnt,
                            vga.v_cnt, vga.frame_start}, {8'd0, e});
    end
  end

  // Interval measurements on the DUT outputs while the raster runs undisturbed.
  int cyc = 0;
  bit measure = 1'b0;
  bit prev_hs = 1'b1, prev_vs = 1'b1, prev_valid = 1'b0;
  int last_hfall = -1, last_line0 = -1, last_vfall = -1, last_fs = -1;
  int act_cnt = 0, max_h = 0, max_v = 0;

  always @(negedge clk) begin
    cyc++;
    if (measure) begin
      if (!prev_valid && vga.valid) last_line0 = cyc;
      if (prev_hs && !vga.hsync) begin
        if (last_hfall >= 0) check_val("hsync_period", cyc - last_hfall, HT * DIV);
        if (last_line0 >= 0 && (cyc - last_line0) < HT * DIV)
          check_val("hsync_offset", cyc - last_line0, (HV + HF) * DIV);
        last_hfall = cyc;
      end
      if (!prev_hs && vga.hsync && last_hfall >= 0)
        check_val("hsync_width", cyc - last_hfall, HS * DIV);
      if (prev_vs && !vga.vsync) begin
        if (last_fs >= 0) check_val("vsync_start", cyc - last_fs, (VV + VF) * HT * DIV);
        last_vfall = cyc;
      end
      if (!prev_vs && vga.vsync && last_vfall >= 0)
        check_val("vsync_width", cyc - last_vfall, VS * HT * DIV);
      if (vga.frame_start) begin
        if (last_fs >= 0) begin
          check_val("frame_period", cyc - last_fs, FRAME_CLKS);
          check_val("active_pixels", act_cnt, HV * VV);
          check_val("max_h_cnt", max_h, HV - 1);
          check_val("max_v_cnt", max_v, VV - 1);
        end
        last_fs = cyc;
        act_cnt = 0;
        max_h   = 0;
        max_v   = 0;
      end
      if (vga.pixel_tick && vga.valid) act_cnt++;
      if (vga.valid && int'(vga.h_cnt) > max_h) max_h = int'(vga.h_cnt);
      if (vga.valid && int'(vga.v_cnt) > max_v) max_v = int'(vga.v_cnt);
    end
    prev_hs    = vga.hsync;
    prev_vs    = vga.vsync;
    prev_valid = vga.valid;
  end

  task automatic check_restart(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vga.pixel_tick && n < 4 * DIV);
    // Release happens mid-cycle, so the tick lands DIV-1 negedges later.
    check_val({tag, "_tick_delay"}, n, DIV - 1);
    @(negedge clk);
    check_val({tag, "_frame_start"}, vga.frame_start, 1);
    check_val({tag, "_valid"}, vga.valid, 1);
    check_val({tag, "_h_cnt"}, vga.h_cnt, 0);
    check_val({tag, "_v_cnt"}, vga.v_cnt, 0);
    check_val({tag, "_syncs"}, {vga.hsync, vga.vsync}, 2'b11);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_val("reset_outputs", {vga.pixel_tick, vga.hsync, vga.vsync, vga.valid, vga.h_cnt,
                                vga.v_cnt, vga.frame_start}, {4'b0110, 19'd0, 1'b0});
    rst     = 1'b0;
    measure = 1'b1;
    check_restart("start");

    repeat (2 * FRAME_CLKS + 8 * DIV) @(negedge clk);

    // Last visible column to first blanking column.
    n = 0;
    while (!(vga.valid && vga.h_cnt == 10'(HV - 1)) && n < FRAME_CLKS) begin
      @(negedge clk);
      n++;
    end
    if (n >= FRAME_CLKS) timeout_fail("wait_last_col");
    repeat (DIV) @(negedge clk);
    check_val("blank_edge", {vga.valid, vga.h_cnt, vga.v_cnt}, 20'd0);

    // Mid-frame reset while hsync is low on a visible line.
    measure = 1'b0;
    n = 0;
    while (!(mv == 5 && !vga.hsync) && n < 2 * FRAME_CLKS) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * FRAME_CLKS) timeout_fail("wait_mid_hsync");
    check_val("mid_hsync_low", vga.hsync, 0);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_hsync", vga.hsync, 1);
    check_val("abort_valid", vga.valid, 0);
    rst = 1'b0;
    check_restart("resume");

    repeat (FRAME_CLKS + 8 * DIV) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, 480, active lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 Parameter CLK_DIV, 4, system clocks per pixel (power of two, at least 2).
REQ-010 clk  input  1  system clock (100 MHz); the block has one clock domain only.
REQ-011 rst  input  1  synchronous, active-high reset.
REQ-012 pixel_tick  output  1  one-clk pulse marking each pixel period.
REQ-013 hsync  output  1  horizontal sync, active low.
REQ-014 vsync  output  1  vertical sync, active low.
REQ-015 valid  output  1  high while the current pixel lies in the active area.
REQ-016 h_cnt  output  10  active-area pixel column; 0 when valid is low.
REQ-017 v_cnt  output  9  active-area pixel row; 0 when valid is low.
REQ-018 frame_start  output  1  one-clk pulse on the first clk of pixel (0,0).

Function
REQ-019 A prescaler counts 0..CLK_DIV-1 and wraps; pixel_tick SHALL be high only in the clk where the prescaler equals CLK_DIV-1.
REQ-020 The internal h counter (10 bits) SHALL advance on each pixel_tick and wrap from H_TOTAL-1 to 0, where H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800).
REQ-021 The internal v counter (10 bits) SHALL advance only on a pixel_tick where h equals H_TOTAL-1, and wrap from V_TOTAL-1 to 0, where V_TOTAL = 525.
REQ-022 A simultaneous h and v wrap SHALL move the counters to (0,0) in a single edge.
REQ-023 hsync SHALL be low exactly for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
REQ-024 vsync SHALL be low exactly for v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
REQ-025 valid SHALL equal (h < H_VISIBLE) AND (v < V_VISIBLE).
REQ-026 h_cnt and v_cnt SHALL equal h and v[8:0] while valid is high, and 0 otherwise.
REQ-027 hsync, vsync, valid, h_cnt, v_cnt and frame_start SHALL be registered, computed from next-state counters, and change on the same clk edge as the counters, with zero skew among them.
REQ-028 All outputs except pixel_tick SHALL hold constant for the CLK_DIV clks of each pixel.
REQ-029 frame_start SHALL be high only in the first clk of pixel (0,0) and low in the remaining CLK_DIV-1 clks.

Reset
REQ-030 While rst is high, the prescaler SHALL be 0, h SHALL be H_TOTAL-1 and v SHALL be V_TOTAL-1.
REQ-031 While rst is high, hsync=1, vsync=1, valid=0, h_cnt=0, v_cnt=0, frame_start=0 and pixel_tick=0.
REQ-032 The first pixel_tick SHALL occur in the CLK_DIV-th clk after rst deasserts; that tick moves the counters to (0,0) and asserts frame_start on the next clk.
REQ-033 Asserting rst mid-frame SHALL abort the frame immediately, with no partial sync pulse held past the reset edge.

Structure
REQ-034 The timing constants, H_TOTAL and V_TOTAL, and the sync start/end positions SHALL be defined in the shared package vga_timing_pkg.
REQ-035 The prescaler SHALL be the single sub-module pixel_tick_div, with ports clk, rst and tick.

Verification
REQ-036 Reset for 5 clks, then release -> pixel_tick in the 4th clk after release; frame_start one clk later with valid=1, h_cnt=0, v_cnt=0, hsync=1, vsync=1.
REQ-037 Run one line -> hsync falling edges 3200 clks apart; each low pulse lasts 384 clks and starts 2624 clks after the h=0 edge.
REQ-038 Run 2 frames -> frame_start pulses 1,680,000 clks apart; vsync low for 6400 clks starting at line 490.
REQ-039 Count pixel_tick with valid high over one frame -> exactly 307200; the maximum h_cnt observed is 639 and the maximum v_cnt is 479.
REQ-040 At h=639 then h=640 -> valid drops, h_cnt=0 and v_cnt=0 on the same edge; at (799,524) -> next pixel is (0,0) with frame_start.
REQ-041 Assert rst for 1 clk while hsync is low at line 200 -> hsync=1 and valid=0 on the next clk; resume timing per REQ-032.
